// File: rtl/lcd_scan.sv
// lcd_scan: 640x480@60 VGA scan generator for a 640x64-pixel Z88 LCD image.
// Each source line is shown on 4 VGA lines, one VRAM nibble covers 4 pixels.
// Every output is delayed 3 mck cycles from the counter state.
// Optional feature macro: LCD_SCAN_TINT_EN (green LCD tint colours).
`timescale 1ns/1ps
module lcd_scan (
  input  logic        mck,
  input  logic        rin,
  input  logic        lcdon,
  output logic [13:0] vram_a,
  input  logic [3:0]  vram_di,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vblank
);

  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd752;
  localparam logic [9:0] V_LAST   = 10'd524;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd492;
  localparam logic [9:0] V_IMG    = 10'd256;
  localparam int         DLY      = 2;   // stage registers before the output register

`ifdef LCD_SCAN_TINT_EN
  localparam logic [11:0] FG_COL = 12'h124;
  localparam logic [11:0] BG_COL = 12'h9B8;
`else
  localparam logic [11:0] FG_COL = 12'h000;
  localparam logic [11:0] BG_COL = 12'hFFF;
`endif

  // Per-pixel attributes carried down the delay pipeline (syncs active-high here).
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       img;
    logic       vb;
    logic [1:0] k;
  } stage_t;

  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        lcd_en_q, lcd_en_d;
  logic [13:0] vram_a_q, vram_a_d;
  stage_t      stage_d;
  stage_t      pipe_q [0:DLY-1];
  stage_t      last_s;
  logic [3:0]  sh_q, sh_d;
  logic        pix;
  logic        hs_q, vs_q, de_q, vb_q;
  logic [11:0] col_q, col_d;
  logic        vis, in_img, frame_start;

  // Next-state for the horizontal and vertical raster counters.
  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = 10'd0;
      vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end
  end

  // Decode the current counter state into pipeline attributes and the VRAM fetch.
  always_comb begin
    frame_start = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
    // lcdon is latched at frame start but must already apply to that first pixel.
    lcd_en_d    = frame_start ? lcdon : lcd_en_q;
    vis         = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    in_img      = vis && (vcnt_q < V_IMG);
    stage_d     = '0;
    stage_d.hs  = (hcnt_q >= H_SYNC_S) && (hcnt_q < H_SYNC_E);
    stage_d.vs  = (vcnt_q >= V_SYNC_S) && (vcnt_q < V_SYNC_E);
    stage_d.de  = vis;
    stage_d.img = in_img && lcd_en_d;
    stage_d.vb  = (hcnt_q == 10'd0) && (vcnt_q == V_VIS);
    stage_d.k   = hcnt_q[1:0];
    // Address goes out at the first pixel of a group; the nibble returns two
    // cycles later, exactly when that pixel reaches the last pipeline stage.
    vram_a_d = vram_a_q;
    if (in_img && (hcnt_q[1:0] == 2'b00)) begin
      vram_a_d = {vcnt_q[7:2], hcnt_q[9:2]};
    end
  end

  assign last_s = pipe_q[DLY-1];

  // Pixel selection: first pixel of a group comes straight from VRAM, the rest from the shifter.
  always_comb begin
    pix  = sh_q[3];
    sh_d = {sh_q[2:0], 1'b0};
    if (last_s.k == 2'b00) begin
      pix  = vram_di[3];
      sh_d = {vram_di[2:0], 1'b0};
    end
    col_d = 12'h000;
    if (last_s.de) begin
      col_d = (last_s.img && pix) ? FG_COL : BG_COL;
    end
  end

  // Raster counters, sampled lcdon and VRAM address register.
  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      hcnt_q   <= 10'd0;
      vcnt_q   <= 10'd0;
      lcd_en_q <= 1'b0;
      vram_a_q <= 14'd0;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      lcd_en_q <= lcd_en_d;
      vram_a_q <= vram_a_d;
    end
  end

  // Attribute delay pipeline.
  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      for (int i = 0; i < DLY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= stage_d;
      for (int i = 1; i < DLY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Output register stage and pixel shift register.
  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      sh_q  <= 4'h0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
      vb_q  <= 1'b0;
      col_q <= 12'h000;
    end else begin
      sh_q  <= sh_d;
      hs_q  <= ~last_s.hs;
      vs_q  <= ~last_s.vs;
      de_q  <= last_s.de;
      vb_q  <= last_s.vb;
      col_q <= col_d;
    end
  end

  assign vram_a = vram_a_q;
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;
  assign vga_de = de_q;
  assign vblank = vb_q;
  assign vga_r  = col_q[11:8];
  assign vga_g  = col_q[7:4];
  assign vga_b  = col_q[3:0];

endmodule

// File: doc/lcd_scan.md
LCD_SCAN -- requirements
Module: lcd_scan

Interface
REQ-001 SHALL have ports: mck  in  1  single clock, all logic on rising edge (pixel clock, 25.175 MHz nominal).
REQ-002 SHALL have ports: rin  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: lcdon  in  1  display enable from Blink; low blanks the image area.
REQ-004 SHALL have ports: vram_a  out  14  VRAM read address; [13:8] source line 0..63, [7:0] nibble column 0..159.
REQ-005 SHALL have ports: vram_di  in  4  VRAM read data, valid one mck cycle after vram_a; bit 3 is the leftmost pixel.
REQ-006 SHALL have ports: vga_hs, vga_vs  out  1 each  syncs, active-low.
REQ-007 SHALL have ports: vga_de  out  1  data enable, high in the 640x480 visible area.
REQ-008 SHALL have ports: vga_r, vga_g, vga_b  out  4 each  pixel colour.
REQ-009 SHALL have ports: vblank  out  1  one-cycle pulse at the first cycle of vertical line 480.

Function
REQ-010 SHALL run counters hcnt 0..799 and vcnt 0..524; hcnt wraps 799->0 and increments vcnt; vcnt wraps 524->0 on hcnt wrap.
REQ-011 SHALL define visible area: hcnt<640 and vcnt<480; hsync low for hcnt 656..751; vsync low for vcnt 490..491.
REQ-012 SHALL define image area: visible and vcnt<256; source line = vcnt[7:2] (each Z88 line shown on 4 VGA lines).
REQ-013 SHALL read one nibble per 4 pixels: for image-area group n (hcnt[9:2]=n), vram_a = {vcnt[7:2], n}, issued early enough that the nibble is in the shift register before its first pixel.
REQ-014 SHALL shift pixels out MSB first: pixel hcnt[1:0]=k displays bit 3-k of nibble n.
REQ-015 SHALL delay vga_hs, vga_vs, vga_de and colour by an identical fixed latency of exactly 3 mck cycles from the counter state, so all outputs stay mutually aligned.
REQ-016 SHALL drive background colour for visible pixels outside the image area and black (0x000) wherever vga_de is low.
REQ-017 SHALL sample lcdon only at hcnt=0,vcnt=0 (frame start); when the sampled value is low the whole image area shows background for that frame.
REQ-018 SHALL hold vram_a at its last value outside the image area (no spurious row jumps); reads outside the image area are don't-care.
REQ-019 SHALL treat lit pixel (bit=1) as foreground colour, 0 as background colour.
REQ-020 SHALL assert vblank for exactly one cycle per frame, aligned with the delayed outputs.

Reset
REQ-021 SHALL on rin high clear hcnt, vcnt, shift register, delay pipeline and sampled lcdon to 0, immediately and independently of mck.
REQ-022 SHALL reset outputs to: vga_hs=1, vga_vs=1, vga_de=0, colour=0x000, vblank=0, vram_a=0.
REQ-023 SHALL, on reset deassertion mid-frame, restart at hcnt=0,vcnt=0 with no partial-line artefacts beyond the first 3 cycles.

Configuration
REQ-024 SHALL honour macro LCD_SCAN_TINT_EN: defined -> foreground 0x124, background 0x9B8 (LCD green tint); undefined -> foreground 0x000, background 0xFFF.

Verification
REQ-025 Reset: hold rin high 10 cycles, release -> outputs at REQ-022 values during reset; first vga_hs falling edge 659 cycles after release (656+3).
REQ-026 Pixel order: VRAM line 0 nibble 0 = 4'b1000, others 0 -> only visible pixel x=0 of VGA lines 0..3 is foreground; x=1..639 background.
REQ-027 Addressing: monitor vram_a during vcnt=8 -> sequence {6'd2, 0..159} in order, one new address per 4 cycles.
REQ-028 Line repeat/edge: VRAM line 63 all 4'hF -> VGA lines 252..255 fully foreground; line 256 fully background.
REQ-029 lcdon: drop lcdon mid-frame -> current frame unchanged; next frame image area all background; raise -> image returns the frame after.
REQ-030 Timing: run 2 frames -> frame period 420000 cycles, vblank period 420000, vsync low 1600 cycles, hsync low 96 cycles per line; run both with and without LCD_SCAN_TINT_EN and check REQ-024 colours.
